// File: rtl/response_frame_builder_if.sv
// Handshake and field bundle between the response requester, the frame builder
// and the TX FIFO. The requester side uses master, the builder uses slave.
interface response_frame_builder_if;
  logic        build_start;
  logic [7:0]  status_code;
  logic [7:0]  cmd_echo;
  logic        is_read;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_data;
  logic [2:0]  data_len;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        build_done;
  logic [7:0]  crc_out;

  modport master (
    output build_start, status_code, cmd_echo, is_read, rsp_addr, rsp_data,
           data_len, tx_ready,
    input  tx_data, tx_valid, busy, build_done, crc_out
  );

  modport slave (
    input  build_start, status_code, cmd_echo, is_read, rsp_addr, rsp_data,
           data_len, tx_ready,
    output tx_data, tx_valid, busy, build_done, crc_out
  );
endinterface

// File: rtl/response_frame_builder.sv
// Serializes a device-to-host response frame (SOF, status, command echo,
// optional address/data, CRC8) byte by byte over a valid/ready stream.
module response_frame_builder #(
  parameter logic [7:0] SOF_RSP        = 8'h5A,
  parameter logic [7:0] CRC_POLY       = 8'h07,
  parameter int         MAX_DATA_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  response_frame_builder_if.slave  bus
);

  localparam logic [2:0] MAX_LEN   = 3'(MAX_DATA_BYTES);
  localparam logic [7:0] STATUS_OK = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_STATUS,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CRC,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  status_reg, status_next;
  logic [7:0]  cmd_reg, cmd_next;
  logic        is_read_reg, is_read_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic [2:0]  len_reg, len_next;
  logic [1:0]  addr_idx_reg, addr_idx_next;
  logic [2:0]  data_idx_reg, data_idx_next;
  logic [7:0]  crc_acc_reg, crc_acc_next;
  logic [7:0]  crc_out_reg, crc_out_next;

  logic        emit;
  logic [7:0]  tx_byte;
  logic [7:0]  addr_bytes [4];
  logic [7:0]  data_bytes [4];
  logic [7:0]  crc_stage  [9];
  logic [7:0]  crc_upd;
  logic [2:0]  len_clamped;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign addr_bytes[gi] = addr_reg[gi*8 +: 8];
      assign data_bytes[gi] = data_reg[gi*8 +: 8];
    end
  endgenerate

  // Unrolled MSB-first CRC8 over the byte currently on tx_data.
  assign crc_stage[0] = crc_acc_reg ^ tx_byte;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_crc
      assign crc_stage[gi+1] = crc_stage[gi][7] ? ({crc_stage[gi][6:0], 1'b0} ^ CRC_POLY)
                                                : {crc_stage[gi][6:0], 1'b0};
    end
  endgenerate
  assign crc_upd = crc_stage[8];

  assign len_clamped = (bus.data_len == 3'd0 || bus.data_len > MAX_LEN) ? MAX_LEN
                                                                       : bus.data_len;

  // Output byte mux; depends only on registered state so it holds during stalls.
  always_comb begin
    emit    = 1'b0;
    tx_byte = 8'h00;
    case (state_reg)
      S_SOF: begin
        emit    = 1'b1;
        tx_byte = SOF_RSP;
      end
      S_STATUS: begin
        emit    = 1'b1;
        tx_byte = status_reg;
      end
      S_CMD: begin
        emit    = 1'b1;
        tx_byte = cmd_reg;
      end
      S_ADDR: begin
        emit    = 1'b1;
        tx_byte = addr_bytes[addr_idx_reg];
      end
      S_DATA: begin
        emit    = 1'b1;
        tx_byte = data_bytes[data_idx_reg[1:0]];
      end
      S_CRC: begin
        emit    = 1'b1;
        tx_byte = crc_acc_reg;
      end
      default: begin
        emit    = 1'b0;
        tx_byte = 8'h00;
      end
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    status_next   = status_reg;
    cmd_next      = cmd_reg;
    is_read_next  = is_read_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    len_next      = len_reg;
    addr_idx_next = addr_idx_reg;
    data_idx_next = data_idx_reg;
    crc_acc_next  = crc_acc_reg;
    crc_out_next  = crc_out_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.build_start) begin
          status_next   = bus.status_code;
          cmd_next      = bus.cmd_echo;
          is_read_next  = bus.is_read;
          addr_next     = bus.rsp_addr;
          data_next     = bus.rsp_data;
          len_next      = len_clamped;
          addr_idx_next = 2'd0;
          data_idx_next = 3'd0;
          crc_acc_next  = 8'h00;
          state_next    = S_SOF;
        end
      end
      S_SOF: begin
        if (bus.tx_ready) state_next = S_STATUS;
      end
      S_STATUS: begin
        if (bus.tx_ready) begin
          crc_acc_next = crc_upd;
          state_next   = S_CMD;
        end
      end
      S_CMD: begin
        if (bus.tx_ready) begin
          crc_acc_next = crc_upd;
          state_next   = (is_read_reg && status_reg == STATUS_OK) ? S_ADDR : S_CRC;
        end
      end
      S_ADDR: begin
        if (bus.tx_ready) begin
          crc_acc_next  = crc_upd;
          addr_idx_next = addr_idx_reg + 2'd1;
          if (addr_idx_reg == 2'd3) state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.tx_ready) begin
          crc_acc_next = crc_upd;
          if (data_idx_reg == len_reg - 3'd1) begin
            data_idx_next = 3'd0;
            state_next    = S_CRC;
          end else begin
            data_idx_next = data_idx_reg + 3'd1;
          end
        end
      end
      S_CRC: begin
        if (bus.tx_ready) begin
          crc_out_next = crc_acc_reg;
          state_next   = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      status_reg   <= 8'h00;
      cmd_reg      <= 8'h00;
      is_read_reg  <= 1'b0;
      addr_reg     <= 32'h0;
      data_reg     <= 32'h0;
      len_reg      <= 3'd0;
      addr_idx_reg <= 2'd0;
      data_idx_reg <= 3'd0;
      crc_acc_reg  <= 8'h00;
      crc_out_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      status_reg   <= status_next;
      cmd_reg      <= cmd_next;
      is_read_reg  <= is_read_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      len_reg      <= len_next;
      addr_idx_reg <= addr_idx_next;
      data_idx_reg <= data_idx_next;
      crc_acc_reg  <= crc_acc_next;
      crc_out_reg  <= crc_out_next;
    end
  end

  assign bus.tx_valid   = emit;
  assign bus.tx_data    = tx_byte;
  assign bus.busy       = (state_reg != S_IDLE);
  assign bus.build_done = (state_reg == S_DONE);
  assign bus.crc_out    = crc_out_reg;

endmodule

// File: tb/tb_response_frame_builder.sv
// Randomized bench for response_frame_builder: frames are compared byte by byte
// against a queue-based model of the response frame format.
module tb_response_frame_builder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  response_frame_builder_if bus();

  response_frame_builder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] exp_crc;
  int         done_cnt;
  int         busy_cycles;
  bit         ready_rand = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  int         frame_no   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  // Expected frame from the format rules: SOF, payload, CRC over payload only.
  task automatic build_expected(input logic [7:0] st, input logic [7:0] cmd, input bit rd,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [2:0] len);
    logic [7:0] payload [$];
    int n;
    logic [7:0] crc;
    n = (len == 0 || len > 4) ? 4 : int'(len);
    payload = {st, cmd};
    if (rd && st == 8'h00) begin
      for (int i = 0; i < 4; i++) payload.push_back(8'(addr >> (8*i)));
      for (int i = 0; i < n; i++) payload.push_back(8'(data >> (8*i)));
    end
    crc = 8'h00;
    exp_q = {};
    exp_q.push_back(8'h5A);
    foreach (payload[i]) begin
      crc = crc8(crc, payload[i]);
      exp_q.push_back(payload[i]);
    end
    exp_q.push_back(crc);
    exp_crc = crc;
  endtask

  // Stream monitor: samples on the falling edge, between active edges.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          expect_eq("hold_valid", 32'(bus.tx_valid), 32'd1);
          expect_eq("hold_data", 32'(bus.tx_data), 32'(prev_data));
        end
        if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
        if (bus.build_done) done_cnt++;
        if (bus.busy) busy_cycles++;
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic start_frame(input logic [7:0] st, input logic [7:0] cmd, input bit rd,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] len);
    int t;
    t = 0;
    while (bus.busy && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    expect_eq("idle_before_start", 32'(bus.busy), 32'd0);
    build_expected(st, cmd, rd, addr, data, len);
    @(posedge clk);
    #1;
    bus.status_code = st;
    bus.cmd_echo    = cmd;
    bus.is_read     = rd;
    bus.rsp_addr    = addr;
    bus.rsp_data    = data;
    bus.data_len    = len;
    bus.build_start = 1'b1;
    got_q.delete();
    done_cnt    = 0;
    busy_cycles = 0;
    @(posedge clk);
    #1;
    bus.build_start = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] st, input logic [7:0] cmd, input bit rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] len, input bit rnd, input bit poke);
    int t;
    int nchk;
    ready_rand = rnd;
    start_frame(st, cmd, rd, addr, data, len);
    if (poke) begin
      @(posedge clk);
      #1;
      bus.status_code = 8'h00;
      bus.cmd_echo    = ~cmd;
      bus.is_read     = ~rd;
      bus.rsp_addr    = ~addr;
      bus.rsp_data    = ~data;
      bus.data_len    = 3'd1;
      bus.build_start = 1'b1;
      @(posedge clk);
      #1;
      bus.build_start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    expect_eq("done_seen", 32'(done_cnt != 0), 32'd1);
    expect_eq("done_count", 32'(done_cnt), 32'd1);
    expect_eq("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
    nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++)
      expect_eq($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    expect_eq("crc_out", 32'(bus.crc_out), 32'(exp_crc));
    expect_eq("busy_after", 32'(bus.busy), 32'd0);
    expect_eq("valid_after", 32'(bus.tx_valid), 32'd0);
    if (!rnd) expect_eq("busy_cycles", 32'(busy_cycles), 32'(exp_q.size() + 1));
    $display("frame %0d: st=%h cmd=%h rd=%0d len=%0d bytes=%0d crc=%h ready_rand=%0d poke=%0d",
             frame_no, st, cmd, rd, len, got_q.size(), bus.crc_out, rnd, poke);
    frame_no++;
  endtask

  initial begin
    int t;
    rst             = 1'b1;
    bus.build_start = 1'b0;
    bus.status_code = 8'h00;
    bus.cmd_echo    = 8'h00;
    bus.is_read     = 1'b0;
    bus.rsp_addr    = 32'h0;
    bus.rsp_data    = 32'h0;
    bus.data_len    = 3'd0;
    bus.tx_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst_valid", 32'(bus.tx_valid), 32'd0);
    expect_eq("rst_data", 32'(bus.tx_data), 32'd0);
    expect_eq("rst_busy", 32'(bus.busy), 32'd0);
    expect_eq("rst_done", 32'(bus.build_done), 32'd0);
    expect_eq("rst_crc", 32'(bus.crc_out), 32'd0);
    rst = 1'b0;

    // Fixed scenarios: error response, write ack, read OK, backpressure, busy poke, clamp.
    run_frame(8'h01, 8'h21, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 3'd4, 1'b0, 1'b0);
    expect_eq("err_crc_const", 32'(bus.crc_out), 32'hF2);
    run_frame(8'h00, 8'h20, 1'b0, 32'h0, 32'h0, 3'd4, 1'b0, 1'b0);
    expect_eq("wr_crc_const", 32'(bus.crc_out), 32'hE0);
    run_frame(8'h00, 8'hA0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3'd4, 1'b0, 1'b0);
    run_frame(8'h00, 8'hA0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3'd4, 1'b1, 1'b0);
    run_frame(8'h00, 8'hA1, 1'b1, 32'h0000_00FF, 32'h0102_0304, 3'd2, 1'b0, 1'b1);
    run_frame(8'h00, 8'hA2, 1'b1, 32'hFFFF_FFFF, 32'h5566_7788, 3'd0, 1'b0, 1'b0);
    run_frame(8'h00, 8'hA3, 1'b1, 32'h8000_0001, 32'h99AA_BBCC, 3'd7, 1'b1, 1'b0);

    // Reset in the middle of the address bytes.
    ready_rand = 1'b0;
    start_frame(8'h00, 8'hA4, 1'b1, 32'h1111_2222, 32'h3333_4444, 3'd3);
    t = 0;
    while (got_q.size() < 4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    expect_eq("reached_addr", 32'(got_q.size() >= 4), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    expect_eq("midrst_valid", 32'(bus.tx_valid), 32'd0);
    expect_eq("midrst_busy", 32'(bus.busy), 32'd0);
    expect_eq("midrst_data", 32'(bus.tx_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      expect_eq("post_rst_idle", 32'(bus.tx_valid), 32'd0);
    end
    run_frame(8'h00, 8'hA5, 1'b1, 32'hABCD_0123, 32'h4567_89EF, 3'd3, 1'b0, 1'b0);

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] st;
      int sel;
      sel = $urandom_range(0, 3);
      st  = (sel < 2) ? 8'h00 : (sel == 2) ? 8'h01 : 8'($urandom);
      run_frame(st, 8'($urandom), 1'($urandom), 32'($urandom), 32'($urandom),
                3'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
